// File: rtl/montgomery_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : montgomery_modexp_ctrl
// Purpose  : Computes y = base^exponent mod m with left-to-right binary
//            square-and-multiply, driving one shared external Montgomery
//            multiplier (mont(a,b) = a*b*R^-1 mod m, R = 2^NBITS) through a
//            start/done pulse handshake. m and m_inv are wired straight to
//            the multiplier and do not pass through this block.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            enable_p          - one-cycle start pulse (accepted in IDLE only)
//            base, exponent    - operands, base < m
//            r2_mod_m          - precomputed R^2 mod m
//            y, done_irq_p     - registered result, one-cycle completion pulse
//            busy              - high from the cycle after start until done
//            mm_enable_p       - one-cycle start pulse to the multiplier
//            mm_a, mm_b        - registered multiplier operands
//            mm_y, mm_done_p   - multiplier result and completion pulse
// Options  : MODEXP_SKIP_LZ_EN - when defined, leading zero exponent bits are
//            consumed one per cycle without issuing a squaring.
// Revision : 1.0 - initial release
// ============================================================================
module montgomery_modexp_ctrl #(
  parameter int NBITS = 2048,
  parameter int EBITS = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_p,
  input  logic [NBITS-1:0] base,
  input  logic [EBITS-1:0] exponent,
  input  logic [NBITS-1:0] r2_mod_m,
  output logic [NBITS-1:0] y,
  output logic             done_irq_p,
  output logic             busy,
  output logic             mm_enable_p,
  output logic [NBITS-1:0] mm_a,
  output logic [NBITS-1:0] mm_b,
  input  logic [NBITS-1:0] mm_y,
  input  logic             mm_done_p
);

  localparam int               c_cnt_w = $clog2(EBITS + 1);
  localparam logic [NBITS-1:0] c_one   = NBITS'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TO_MONT   = 3'd1,
    S_INIT      = 3'd2,
    S_SQR       = 3'd3,
    S_MUL       = 3'd4,
    S_FROM_MONT = 3'd5,
    S_DONE      = 3'd6,
    S_SCAN      = 3'd7
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [NBITS-1:0]     r_acc;
  logic [NBITS-1:0]     r_bm;
  logic [NBITS-1:0]     r_r2;
  logic [EBITS-1:0]     r_e_sh;
  logic [c_cnt_w-1:0]   r_bit_cnt;

  logic                 w_start;
  logic                 w_op_state;
  logic                 w_op_done;
  logic                 w_last_bit;
  logic                 w_issue;
  logic [NBITS-1:0]     w_mm_a_next;
  logic [NBITS-1:0]     w_mm_b_next;
  logic                 w_shift;
  logic                 w_acc_load;
  logic                 w_bm_load;
  logic                 w_y_load;

  assign w_start    = (r_state == S_IDLE) && enable_p;
  assign w_op_state = (r_state == S_TO_MONT) || (r_state == S_INIT) ||
                      (r_state == S_SQR) || (r_state == S_MUL) ||
                      (r_state == S_FROM_MONT);
  // The first cycle of every multiply state is the ISSUE cycle (mm_enable_p
  // high); a done pulse is only honoured in the WAIT cycles that follow.
  assign w_op_done  = w_op_state && !mm_enable_p && mm_done_p;
  assign w_last_bit = (r_bit_cnt == c_cnt_w'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and issue decode. Operands for the next multiply come from
  // mm_y directly when the previous result lands in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_mm_a_next  = mm_a;
    w_mm_b_next  = mm_b;
    w_shift      = 1'b0;
    w_acc_load   = 1'b0;
    w_bm_load    = 1'b0;
    w_y_load     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (enable_p) begin
          // mm_a keeps the latched base for the whole first multiply.
          w_state_next = S_TO_MONT;
          w_issue      = 1'b1;
          w_mm_a_next  = base;
          w_mm_b_next  = r2_mod_m;
        end
      end

      S_TO_MONT: begin
        if (w_op_done) begin
          w_bm_load    = 1'b1;
          w_state_next = S_INIT;
          w_issue      = 1'b1;
          w_mm_a_next  = r_r2;
          w_mm_b_next  = c_one;
        end
      end

      S_INIT: begin
        if (w_op_done) begin
          w_acc_load   = 1'b1;
`ifdef MODEXP_SKIP_LZ_EN
          w_state_next = S_SCAN;
`else
          w_state_next = S_SQR;
          w_issue      = 1'b1;
          w_mm_a_next  = mm_y;
          w_mm_b_next  = mm_y;
`endif
        end
      end

`ifdef MODEXP_SKIP_LZ_EN
      S_SCAN: begin
        if (r_e_sh[EBITS-1]) begin
          w_state_next = S_SQR;
          w_issue      = 1'b1;
          w_mm_a_next  = r_acc;
          w_mm_b_next  = r_acc;
        end else begin
          w_shift = 1'b1;
          if (w_last_bit) begin
            // Exponent was zero: acc still holds R mod m.
            w_state_next = S_FROM_MONT;
            w_issue      = 1'b1;
            w_mm_a_next  = r_acc;
            w_mm_b_next  = c_one;
          end
        end
      end
`endif

      S_SQR: begin
        if (w_op_done) begin
          w_acc_load = 1'b1;
          w_issue    = 1'b1;
          if (r_e_sh[EBITS-1]) begin
            w_state_next = S_MUL;
            w_mm_a_next  = mm_y;
            w_mm_b_next  = r_bm;
          end else begin
            w_shift = 1'b1;
            if (w_last_bit) begin
              w_state_next = S_FROM_MONT;
              w_mm_a_next  = mm_y;
              w_mm_b_next  = c_one;
            end else begin
              w_state_next = S_SQR;
              w_mm_a_next  = mm_y;
              w_mm_b_next  = mm_y;
            end
          end
        end
      end

      S_MUL: begin
        if (w_op_done) begin
          w_acc_load = 1'b1;
          w_issue    = 1'b1;
          w_shift    = 1'b1;
          if (w_last_bit) begin
            w_state_next = S_FROM_MONT;
            w_mm_a_next  = mm_y;
            w_mm_b_next  = c_one;
          end else begin
            w_state_next = S_SQR;
            w_mm_a_next  = mm_y;
            w_mm_b_next  = mm_y;
          end
        end
      end

      S_FROM_MONT: begin
        if (w_op_done) begin
          w_y_load     = 1'b1;
          w_state_next = S_DONE;
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_bm        <= '0;
      r_r2        <= '0;
      r_e_sh      <= '0;
      r_bit_cnt   <= '0;
      y           <= '0;
      done_irq_p  <= 1'b0;
      busy        <= 1'b0;
      mm_enable_p <= 1'b0;
      mm_a        <= '0;
      mm_b        <= '0;
    end else begin
      mm_enable_p <= w_issue;
      mm_a        <= w_mm_a_next;
      mm_b        <= w_mm_b_next;
      done_irq_p  <= w_y_load;

      if (w_start) begin
        r_e_sh    <= exponent;
        r_r2      <= r2_mod_m;
        r_bit_cnt <= c_cnt_w'(EBITS);
        busy      <= 1'b1;
      end else if (w_shift) begin
        r_e_sh    <= r_e_sh << 1;
        r_bit_cnt <= r_bit_cnt - c_cnt_w'(1);
      end

      if (w_acc_load) begin
        r_acc <= mm_y;
      end
      if (w_bm_load) begin
        r_bm <= mm_y;
      end
      if (w_y_load) begin
        y    <= mm_y;
        busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/montgomery_modexp_ctrl.md
Name: montgomery_modexp_ctrl

Overview:
- Sequencer that computes y = base^exponent mod m using left-to-right binary square-and-multiply.
- Drives one shared external Montgomery multiplier, which computes a*b*R^-1 mod m, through its enable_p / done_irq_p pulse handshake.
- Steps: base into Montgomery domain, accumulator initialisation, the square/multiply schedule, then conversion out of the domain by multiplying by 1.
- Sits between the host/register layer and the multiplier instance. m and m_inv are wired to the multiplier directly, not through this block.

Parameters:
- NBITS, 2048, operand/modulus width; must equal the multiplier's NBITS.
- EBITS, 2048, exponent width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- enable_p  input  1  one-cycle start pulse.
- base  input  NBITS  base, must be less than m.
- exponent  input  EBITS  exponent.
- r2_mod_m  input  NBITS  precomputed R^2 mod m, with R = 2^NBITS.
- y  output  NBITS  result, registered.
- done_irq_p  output  1  one-cycle completion pulse.
- busy  output  1  high from the cycle after an accepted start until done_irq_p.
- mm_enable_p  output  1  one-cycle start pulse to the multiplier.
- mm_a  output  NBITS  multiplier operand a, registered.
- mm_b  output  NBITS  multiplier operand b, registered.
- mm_y  input  NBITS  multiplier result.
- mm_done_p  input  1  multiplier completion pulse.

Behaviour:
- Reset: all outputs 0; state IDLE; internal registers acc, bm, e_sh, bit_cnt cleared.
- Start:
  - enable_p in IDLE latches exponent into e_sh and base and r2_mod_m into internal registers; bit_cnt is set to EBITS; next state is TO_MONT.
  - enable_p in any other state is ignored.
  - m and m_inv must be held stable by the user while busy.
- Operation handshake, used by every multiply:
  - ISSUE cycle: mm_a/mm_b are driven and mm_enable_p=1 for exactly one cycle.
  - WAIT: hold until mm_done_p. mm_y is captured on the mm_done_p cycle, and the next ISSUE occurs in the following cycle.
  - mm_a/mm_b stay stable from ISSUE through mm_done_p.
  - mm_done_p outside WAIT is ignored. This includes a late pulse after reset.
- State sequence, in order of execution:
  - TO_MONT: bm = mont(base, r2).
  - INIT: acc = mont(r2, 1), which is R mod m.
  - SQR: acc = mont(acc, acc).
  - Then, if e_sh[EBITS-1]=1, MUL: acc = mont(acc, bm).
  - Then shift e_sh left by 1 and decrement bit_cnt. If bit_cnt reaches 0 go to FROM_MONT, else go to SQR.
  - FROM_MONT: acc = mont(acc, 1).
  - DONE: y = acc, done_irq_p = 1 for one cycle, busy = 0, return to IDLE.
- Multiply count: 3 + EBITS + popcount(exponent).
- Cycle overhead: exactly 1 cycle per operation (ISSUE) plus the DONE cycle, in addition to the multiplier latency.
- y holds its value until the next DONE; it is not cleared on start.
- Boundaries:
  - exponent = 0: y = 1 mod m. This is 1, or 0 when m = 1.
  - base = 0 with exponent ≠ 0: y = 0.
  - exponent all ones: EBITS consecutive SQR+MUL pairs.
  - enable_p in the same cycle as DONE is ignored; the block accepts a start from IDLE only, i.e. the cycle after done_irq_p at earliest.
- Reset mid-operation: returns to IDLE in the next cycle. mm_enable_p=0, busy=0, y=0, done_irq_p is not generated, and any in-flight multiplier result is discarded.

Optional Feature:
- Macro: MODEXP_SKIP_LZ_EN.
- Defined:
  - After INIT, a SCAN state consumes leading zero exponent bits at one bit per cycle, shifting e_sh and decrementing bit_cnt without issuing a multiply.
  - SCAN exits to SQR on the first 1 bit.
  - If bit_cnt reaches 0 in SCAN (exponent = 0), it exits to FROM_MONT.
  - Multiply count: 3 + (EBITS - lz) + popcount.
- Not defined: there is no SCAN state, and every bit issues a SQR.
- Results are identical either way.

Test Plan:
- All scenarios use NBITS=16, EBITS=8, m=241, a behavioural Montgomery model with R=2^16, and r2_mod_m = 2^32 mod 241.
- base=3, exponent=0x05 -> y=2; done_irq_p pulses once; 13 mm_enable_p pulses (8 with MODEXP_SKIP_LZ_EN).
- base=7, exponent=0x00 -> y=1; 11 mm_enable_p pulses (3 with the macro).
- base=0, exponent=0xFF -> y=0; 19 mm_enable_p pulses; busy high throughout.
- Multiplier latency set to 1 and 5 cycles for base=3, exponent=0x05 -> identical y=2; total cycles from enable_p to done_irq_p equal 13*(latency+1)+2 without the macro.
- enable_p re-pulsed while busy, with different operands -> ignored; first result y=2 unchanged; mm_a/mm_b stable during WAIT.
- rst asserted during the 4th WAIT, then a late mm_done_p -> IDLE, y=0, busy=0, no done_irq_p; a fresh start completes correctly.
